fetch_stage: RTL and testbench



---
 rtl/fetch_pkg.sv | 14 +
 rtl/if_id_reg.sv | 59 +++++
 rtl/fetch_stage.sv | 199 +++++++++++++++++++
 tb/tb_fetch_stage.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    REQ,
    WAIT,
    HOLD,
    DROP,
    HALT
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush > stall > load > bubble.
// Carries the misalignment flag only when FETCH_MISALIGN_EN is defined.
module if_id_reg #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            load,
  input  logic [31:0]     load_instr,
  input  logic [XLEN-1:0] load_pc,
`ifdef FETCH_MISALIGN_EN
  input  logic            load_misalign,
  output logic            misalign_d,
`endif
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus4_d,
  output logic            valid_d
);

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_d   <= NOP_INSTR;
      pc_d      <= '0;
      pcplus4_d <= '0;
      valid_d   <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      misalign_d <= 1'b0;
`endif
    end else if (flush) begin
      // PC fields are left as they were; only the instruction is killed.
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      misalign_d <= 1'b0;
`endif
    end else if (!stall) begin
      if (load) begin
        instr_d   <= load_instr;
        pc_d      <= load_pc;
        pcplus4_d <= load_pc + XLEN'(4);
        valid_d   <= 1'b1;
`ifdef FETCH_MISALIGN_EN
        misalign_d <= load_misalign;
`endif
      end else begin
        instr_d <= NOP_INSTR;
        valid_d <= 1'b0;
`ifdef FETCH_MISALIGN_EN
        misalign_d <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage with one outstanding imem request and IF/ID register.
// Optional FETCH_MISALIGN_EN: misaligned redirect targets raise InstrMisalignD and halt fetch.
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            ImemReq,
  output logic [XLEN-1:0] ImemAddr,
  input  logic            ImemGnt,
  input  logic            ImemRvalid,
  input  logic [31:0]     ImemRdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
`ifdef FETCH_MISALIGN_EN
  ,
  output logic            InstrMisalignD
`endif
);

  import fetch_pkg::*;

  fetch_state_t    state;
  fetch_state_t    redir_idle;
  fetch_state_t    redir_busy;
  logic [XLEN-1:0] pcf;
  logic [XLEN-1:0] reqpc;
  logic [XLEN-1:0] target;
  logic [31:0]     skid;
  logic            load;
  logic [31:0]     load_instr;
  logic [XLEN-1:0] load_pc;

`ifdef FETCH_MISALIGN_EN
  logic misaligned;
  logic misalign_pend;
  logic halt_outst;
  logic load_misalign;

  assign target     = PCTargetE;
  assign misaligned = |PCTargetE[1:0];
`else
  assign target = PCTargetE & {{(XLEN-2){1'b1}}, 2'b00};
`endif

  assign ImemAddr = pcf;

  always_comb begin
    ImemReq    = !reset && (state == REQ) && !StallF && !PCSrcE;
    load       = 1'b0;
    load_instr = ImemRdata;
    load_pc    = reqpc;
`ifdef FETCH_MISALIGN_EN
    load_misalign = 1'b0;
`endif
    if (!PCSrcE && !StallD) begin
      case (state)
        WAIT: load = ImemRvalid;
        HOLD: begin
          load       = 1'b1;
          load_instr = skid;
        end
`ifdef FETCH_MISALIGN_EN
        HALT: if (misalign_pend && !FlushD) begin
          load          = 1'b1;
          load_instr    = NOP_INSTR;
          load_pc       = pcf;
          load_misalign = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // A response arriving together with the redirect is consumed in that cycle,
  // so the FSM goes to REQ instead of DROP-waiting for a response that never comes.
  always_comb begin
    redir_idle = REQ;
    redir_busy = ImemRvalid ? REQ : DROP;
`ifdef FETCH_MISALIGN_EN
    if (misaligned) begin
      redir_idle = HALT;
      redir_busy = HALT;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= REQ;
      pcf   <= RESET_PC;
      reqpc <= '0;
      skid  <= '0;
`ifdef FETCH_MISALIGN_EN
      misalign_pend <= 1'b0;
      halt_outst    <= 1'b0;
`endif
    end else begin
      if (PCSrcE) pcf <= target;
`ifdef FETCH_MISALIGN_EN
      if (PCSrcE && misaligned)       misalign_pend <= 1'b1;
      else if (load && state == HALT) misalign_pend <= 1'b0;
`endif
      case (state)
        REQ: begin
          if (PCSrcE) begin
            state <= redir_idle;
`ifdef FETCH_MISALIGN_EN
            halt_outst <= 1'b0;
`endif
          end else if (ImemReq && ImemGnt) begin
            reqpc <= pcf;
            pcf   <= pcf + XLEN'(4);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (PCSrcE) begin
            state <= redir_busy;
`ifdef FETCH_MISALIGN_EN
            halt_outst <= !ImemRvalid;
`endif
          end else if (ImemRvalid) begin
            if (StallD) begin
              skid  <= ImemRdata;
              state <= HOLD;
            end else begin
              state <= REQ;
            end
          end
        end
        HOLD: begin
          if (PCSrcE) begin
            state <= redir_idle;
`ifdef FETCH_MISALIGN_EN
            halt_outst <= 1'b0;
`endif
          end else if (!StallD) begin
            state <= REQ;
          end
        end
        DROP: begin
          if (PCSrcE) begin
            state <= redir_busy;
`ifdef FETCH_MISALIGN_EN
            halt_outst <= !ImemRvalid;
`endif
          end else if (ImemRvalid) begin
            state <= REQ;
          end
        end
`ifdef FETCH_MISALIGN_EN
        HALT: begin
          if (ImemRvalid) halt_outst <= 1'b0;
          // A request may still be in flight from before the halt; drain it first.
          if (PCSrcE) begin
            if (misaligned)                     state <= HALT;
            else if (halt_outst && !ImemRvalid) state <= DROP;
            else                                state <= REQ;
          end
        end
`endif
        default: state <= REQ;
      endcase
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk           (clk),
    .reset         (reset),
    .stall         (StallD),
    .flush         (FlushD),
    .load          (load),
    .load_instr    (load_instr),
    .load_pc       (load_pc),
`ifdef FETCH_MISALIGN_EN
    .load_misalign (load_misalign),
    .misalign_d    (InstrMisalignD),
`endif
    .instr_d       (InstrD),
    .pc_d          (PCD),
    .pcplus4_d     (PCPlus4D),
    .valid_d       (ValidD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage with a variable-latency imem model and
// an expected-instruction scoreboard.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        ImemReq, ImemGnt, ImemRvalid;
  logic [31:0] ImemAddr, ImemRdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
`ifdef FETCH_MISALIGN_EN
  logic        InstrMisalignD;
`endif

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN      (32),
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .ImemReq    (ImemReq),
    .ImemAddr   (ImemAddr),
    .ImemGnt    (ImemGnt),
    .ImemRvalid (ImemRvalid),
    .ImemRdata  (ImemRdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
`ifdef FETCH_MISALIGN_EN
    ,
    .InstrMisalignD (InstrMisalignD)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          lat        = 1;
  int          cyc        = 0;
  int          last_deliv = -100;
  int          deliv_cnt  = 0;
  int          deliv_gap  = 0;
  bit          outstanding = 1'b0;
  int          cnt        = 0;
  logic [31:0] pend_addr  = '0;
  logic        pre_req;
  logic [31:0] pre_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return 32'hA500_0003 ^ (a << 4);
  endfunction

  // One clock: drive imem response, sample pre-edge request, check IF/ID after the edge.
  task automatic tick();
    exp_t e;
    if (reset) begin
      outstanding = 1'b0;
      ImemRvalid  = 1'b0;
    end else if (outstanding && cnt == 0) begin
      ImemRvalid  = 1'b1;
      ImemRdata   = mem_word(pend_addr);
      outstanding = 1'b0;
    end else begin
      ImemRvalid = 1'b0;
      ImemRdata  = '0;
      if (outstanding) cnt--;
    end
    #1;
    pre_req  = ImemReq;
    pre_addr = ImemAddr;
    if (!reset && ImemReq && ImemGnt) begin
      outstanding = 1'b1;
      pend_addr   = ImemAddr;
      cnt         = lat - 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (ValidD && !StallD && !reset) begin
      deliv_cnt++;
      deliv_gap  = cyc - last_deliv;
      last_deliv = cyc;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_delivery: InstrD=%h PCD=%h, required no delivery", InstrD, PCD);
      end else begin
        e = exp_q.pop_front();
        if (InstrD !== e.instr || PCD !== e.pc || PCPlus4D !== e.pc + 32'd4) begin
          mismatched++;
          $display("FAIL scoreboard: InstrD=%h PCD=%h PCPlus4D=%h, required %h %h %h",
                   InstrD, PCD, PCPlus4D, e.instr, e.pc, e.pc + 32'd4);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    compared++;
    if (pre_req !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_req: ImemReq=%b, required 0", pre_req);
    end
    compared++;
    if (InstrD !== NOP || PCD !== 32'h0 || PCPlus4D !== 32'h0 || ValidD !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ifid: InstrD=%h PCD=%h PCPlus4D=%h ValidD=%b, required %h 0 0 0",
               InstrD, PCD, PCPlus4D, ValidD, NOP);
    end
    reset  = 1'b0;
    StallF = 1'b1;
    #1;
    compared++;
    if (ImemAddr !== RESET_PC || ImemReq !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_pc: ImemAddr=%h ImemReq=%b, required %h 0", ImemAddr, ImemReq, RESET_PC);
    end
  endtask

  task automatic test_zero_wait();
    lat = 1;
    deliv_cnt = 0;
    push(32'h0050_0093, 32'h0);
    push(32'h00A0_0113, 32'h4);
    StallF = 1'b0;
    for (int i = 0; i < 20 && deliv_cnt < 2; i++) tick();
    StallF = 1'b1;
    compared++;
    if (deliv_cnt !== 2) begin
      mismatched++;
      $display("FAIL zw_count: delivered %0d, required 2", deliv_cnt);
    end
    compared++;
    if (deliv_gap !== 2) begin
      mismatched++;
      $display("FAIL zw_rate: gap %0d cycles, required 2", deliv_gap);
    end
  endtask

  task automatic test_stall_d();
    logic [31:0] held;
    logic        heldv;
    deliv_cnt = 0;
    push(mem_word(32'h8), 32'h8);
    StallF = 1'b0;
    tick();
    compared++;
    if (pre_req !== 1'b1 || pre_addr !== 32'h8) begin
      mismatched++;
      $display("FAIL sd_req: ImemReq=%b ImemAddr=%h, required 1 00000008", pre_req, pre_addr);
    end
    StallD = 1'b1;
    held   = InstrD;
    heldv  = ValidD;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (pre_req !== 1'b0 || InstrD !== held || ValidD !== heldv) begin
        mismatched++;
        $display("FAIL sd_hold: ImemReq=%b InstrD=%h ValidD=%b, required 0 %h %b",
                 pre_req, InstrD, ValidD, held, heldv);
      end
    end
    StallD = 1'b0;
    StallF = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    compared++;
    if (deliv_cnt !== 1 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL sd_once: delivered %0d pending %0d, required 1 0", deliv_cnt, exp_q.size());
    end
  endtask

  task automatic test_redirect_wait();
    bit found = 1'b0;
    lat = 5;
    StallF = 1'b0;
    tick();
    compared++;
    if (pre_req !== 1'b1 || pre_addr !== 32'hC) begin
      mismatched++;
      $display("FAIL rw_req: ImemReq=%b ImemAddr=%h, required 1 0000000c", pre_req, pre_addr);
    end
    tick();
    tick();
    PCSrcE = 1'b1; PCTargetE = 32'h100; FlushD = 1'b1;
    tick();
    PCSrcE = 1'b0; PCTargetE = '0; FlushD = 1'b0;
    deliv_cnt = 0;
    push(mem_word(32'h100), 32'h100);
    for (int i = 0; i < 40 && deliv_cnt < 1; i++) begin
      tick();
      if (pre_req && !found) begin
        found = 1'b1;
        compared++;
        if (pre_addr !== 32'h100) begin
          mismatched++;
          $display("FAIL rw_addr: ImemAddr=%h, required 00000100", pre_addr);
        end
      end
    end
    StallF = 1'b1;
    compared++;
    if (!found || deliv_cnt !== 1) begin
      mismatched++;
      $display("FAIL rw_timeout: req_seen=%b delivered %0d, required 1 1", found, deliv_cnt);
    end
  endtask

  task automatic test_redirect_same_cycle();
    lat = 1;
    StallF = 1'b0;
    tick();
    compared++;
    if (pre_req !== 1'b1 || pre_addr !== 32'h104) begin
      mismatched++;
      $display("FAIL sc_req: ImemReq=%b ImemAddr=%h, required 1 00000104", pre_req, pre_addr);
    end
    PCSrcE = 1'b1; PCTargetE = 32'h40; FlushD = 1'b1;
    tick();
    compared++;
    if (ValidD !== 1'b0 || InstrD !== NOP) begin
      mismatched++;
      $display("FAIL sc_flush: ValidD=%b InstrD=%h, required 0 %h", ValidD, InstrD, NOP);
    end
    PCSrcE = 1'b0; PCTargetE = '0; FlushD = 1'b0;
    deliv_cnt = 0;
    push(mem_word(32'h40), 32'h40);
    for (int i = 0; i < 20 && deliv_cnt < 1; i++) tick();
    StallF = 1'b1;
    compared++;
    if (deliv_cnt !== 1) begin
      mismatched++;
      $display("FAIL sc_timeout: delivered %0d, required 1", deliv_cnt);
    end
  endtask

  task automatic test_wrap_and_reset();
    StallF = 1'b1;
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    tick();
    PCSrcE = 1'b0; PCTargetE = '0;
    compared++;
    if (ImemAddr !== 32'hFFFF_FFFC) begin
      mismatched++;
      $display("FAIL wrap_redirect: ImemAddr=%h, required fffffffc", ImemAddr);
    end
    lat = 1;
    deliv_cnt = 0;
    push(mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC);
    StallF = 1'b0;
    for (int i = 0; i < 20 && deliv_cnt < 1; i++) tick();
    StallF = 1'b1;
    StallD = 1'b1;
    compared++;
    if (deliv_cnt !== 1 || PCPlus4D !== 32'h0 || ImemAddr !== 32'h0) begin
      mismatched++;
      $display("FAIL wrap_pc4: delivered %0d PCPlus4D=%h ImemAddr=%h, required 1 0 0",
               deliv_cnt, PCPlus4D, ImemAddr);
    end
    PCSrcE = 1'b1; PCTargetE = 32'h80;
    tick();
    PCSrcE = 1'b0; PCTargetE = '0;
    lat = 5;
    StallF = 1'b0;
    tick();
    compared++;
    if (pre_req !== 1'b1 || pre_addr !== 32'h80) begin
      mismatched++;
      $display("FAIL rst_req: ImemReq=%b ImemAddr=%h, required 1 00000080", pre_req, pre_addr);
    end
    tick();
    reset = 1'b1;
    tick();
    compared++;
    if (pre_req !== 1'b0 || ValidD !== 1'b0 || InstrD !== NOP) begin
      mismatched++;
      $display("FAIL rst_mid_wait: ImemReq=%b ValidD=%b InstrD=%h, required 0 0 %h",
               pre_req, ValidD, InstrD, NOP);
    end
    reset  = 1'b0;
    StallD = 1'b0;
    lat    = 1;
    #1;
    compared++;
    if (ImemAddr !== RESET_PC || ImemReq !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_pc: ImemAddr=%h ImemReq=%b, required %h 1", ImemAddr, ImemReq, RESET_PC);
    end
    deliv_cnt = 0;
    push(mem_word(RESET_PC), RESET_PC);
    for (int i = 0; i < 20 && deliv_cnt < 1; i++) tick();
    StallF = 1'b1;
    compared++;
    if (deliv_cnt !== 1) begin
      mismatched++;
      $display("FAIL rst_refetch: delivered %0d, required 1", deliv_cnt);
    end
  endtask

`ifdef FETCH_MISALIGN_EN
  task automatic test_misalign();
    bit found = 1'b0;
    StallF = 1'b1;
    PCSrcE = 1'b1; PCTargetE = 32'h102;
    tick();
    PCSrcE = 1'b0; PCTargetE = '0;
    StallF = 1'b0;
    deliv_cnt = 0;
    push(NOP, 32'h102);
    tick();
    compared++;
    if (InstrMisalignD !== 1'b1 || PCD !== 32'h102 || ValidD !== 1'b1) begin
      mismatched++;
      $display("FAIL mis_load: InstrMisalignD=%b PCD=%h ValidD=%b, required 1 00000102 1",
               InstrMisalignD, PCD, ValidD);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      compared++;
      if (pre_req !== 1'b0) begin
        mismatched++;
        $display("FAIL mis_halt: ImemReq=%b, required 0", pre_req);
      end
    end
    PCSrcE = 1'b1; PCTargetE = 32'h200;
    tick();
    PCSrcE = 1'b0; PCTargetE = '0;
    deliv_cnt = 0;
    push(mem_word(32'h200), 32'h200);
    for (int i = 0; i < 20 && deliv_cnt < 1; i++) begin
      tick();
      if (pre_req && !found) begin
        found = 1'b1;
        compared++;
        if (pre_addr !== 32'h200) begin
          mismatched++;
          $display("FAIL mis_resume: ImemAddr=%h, required 00000200", pre_addr);
        end
      end
    end
    StallF = 1'b1;
    compared++;
    if (deliv_cnt !== 1 || InstrMisalignD !== 1'b0) begin
      mismatched++;
      $display("FAIL mis_clear: delivered %0d InstrMisalignD=%b, required 1 0", deliv_cnt, InstrMisalignD);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrcE = 1'b0; PCTargetE = '0; ImemGnt = 1'b1;
    ImemRvalid = 1'b0; ImemRdata = '0;
    @(negedge clk);
    test_reset();
    test_zero_wait();
    test_stall_d();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_wrap_and_reset();
`ifdef FETCH_MISALIGN_EN
    test_misalign();
`endif
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover: %0d expected instructions never delivered, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
